// File: rtl/cache_pkg.sv
// cache_pkg: shared sizing, address base and FSM states for the two-way read cache.
package cache_pkg;

  localparam int SETS    = 64;
  localparam int TAG_W   = 10;
  localparam int IDX_W   = $clog2(SETS);
  localparam int BLOCK_W = 64;

  // Data memory starts here; it is removed before the tag/index/word fields are taken.
  localparam logic [31:0] ADDR_OFFSET = 32'd1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cache_controller_if.sv
// cache_controller_if: MEM-stage request bus plus the SRAM-controller bus of the cache.
// slave is the cache's view, master is the view of the surrounding pipeline/SRAM side.
interface cache_controller_if;
  import cache_pkg::*;

  logic               mem_r_en;
  logic               mem_w_en;
  logic [31:0]        address;
  logic [31:0]        w_data;
  logic [31:0]        r_data;
  logic               ready;
  logic               sram_r_en;
  logic               sram_w_en;
  logic [18:0]        sram_address;
  logic [31:0]        sram_w_data;
  logic [BLOCK_W-1:0] sram_r_data;
  logic               sram_ready;

  modport slave (
    input  mem_r_en, mem_w_en, address, w_data, sram_r_data, sram_ready,
    output r_data, ready, sram_r_en, sram_w_en, sram_address, sram_w_data
  );

  modport master (
    output mem_r_en, mem_w_en, address, w_data, sram_r_data, sram_ready,
    input  r_data, ready, sram_r_en, sram_w_en, sram_address, sram_w_data
  );

endinterface

// File: rtl/cache_set_array.sv
// cache_set_array: valid/tag/data/LRU storage of the two ways, hit detection and
// refill victim choice. The single write port always targets the set being looked up.
module cache_set_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   index,
  input  logic [TAG_W-1:0]   tag,
  output logic               hit,
  output logic               hit_way,
  output logic [BLOCK_W-1:0] hit_block,
  output logic               victim_way,
  input  logic               wr_en,
  input  logic               wr_way,
  input  logic [BLOCK_W-1:0] wr_block,
  input  logic               lru_en,
  input  logic               lru_val
);

  logic [SETS-1:0]    valid_q [2];
  logic [SETS-1:0]    lru_q;
  logic [TAG_W-1:0]   tag_q   [2][SETS];
  logic [BLOCK_W-1:0] data_q  [2][SETS];
  logic               hit0;
  logic               hit1;

  // Lookup: compare both ways, pick the hitting block, and pick invalid ways before the LRU way.
  always_comb begin
    hit0      = valid_q[0][index] && (tag_q[0][index] == tag);
    hit1      = valid_q[1][index] && (tag_q[1][index] == tag);
    hit       = hit0 | hit1;
    hit_way   = hit1 & ~hit0;
    hit_block = hit_way ? data_q[1][index] : data_q[0][index];
    if (!valid_q[0][index])
      victim_way = 1'b0;
    else if (!valid_q[1][index])
      victim_way = 1'b1;
    else
      victim_way = lru_q[index];
  end

  // Valid and LRU bits are the only state that reset must clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      if (wr_en)
        valid_q[wr_way][index] <= 1'b1;
      if (lru_en)
        lru_q[index] <= lru_val;
    end
  end

  // Tag and data arrays are meaningless until their valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_way][index]  <= tag;
      data_q[wr_way][index] <= wr_block;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// cache_controller: two-way set-associative read cache with write-through stores.
// Optional build macro CACHE_PERF_CNT_EN adds saturating hit_count/miss_count outputs.
module cache_controller
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  cache_controller_if.slave  bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  state_t             state_q;
  state_t             state_d;
  logic               first_q;
  logic [31:0]        a;
  logic [IDX_W-1:0]   index;
  logic [TAG_W-1:0]   tag;
  logic               word_sel;
  logic               hit;
  logic               hit_way;
  logic               victim_way;
  logic [BLOCK_W-1:0] hit_block;
  logic [31:0]        hit_word;
  logic               wr_en;
  logic               wr_way;
  logic [BLOCK_W-1:0] wr_block;
  logic               lru_en;
  logic               lru_val;
  logic               sram_done;
  logic               ready;
  logic [31:0]        r_data;
  logic               sram_r_en;
  logic               sram_w_en;
  logic [18:0]        sram_address;
  logic [31:0]        sram_w_data;
  logic               unused_bits;

  assign a           = bus.address - ADDR_OFFSET;
  assign word_sel    = a[2];
  assign index       = a[8:3];
  assign tag         = a[18:9];
  assign hit_word    = word_sel ? hit_block[63:32] : hit_block[31:0];
  assign unused_bits = ^{a[31:19], a[1:0], bus.address[31:19]};

  // The SRAM controller reports ready from its own idle state, so the first FILL/WRITE cycle never completes.
  assign sram_done = ((state_q == FILL) || (state_q == WRITE)) && !first_q && bus.sram_ready;

  cache_set_array u_array (
    .clk        (clk),
    .rst        (rst),
    .index      (index),
    .tag        (tag),
    .hit        (hit),
    .hit_way    (hit_way),
    .hit_block  (hit_block),
    .victim_way (victim_way),
    .wr_en      (wr_en),
    .wr_way     (wr_way),
    .wr_block   (wr_block),
    .lru_en     (lru_en),
    .lru_val    (lru_val)
  );

  // FSM next state, pipeline/SRAM outputs and the array write controls.
  always_comb begin
    state_d      = state_q;
    ready        = 1'b0;
    r_data       = '0;
    sram_r_en    = 1'b0;
    sram_w_en    = 1'b0;
    sram_address = '0;
    sram_w_data  = '0;
    wr_en        = 1'b0;
    wr_way       = victim_way;
    wr_block     = bus.sram_r_data;
    lru_en       = 1'b0;
    lru_val      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_w_en) begin
          state_d = WRITE;
          if (hit) begin
            wr_en    = 1'b1;
            wr_way   = hit_way;
            wr_block = word_sel ? {bus.w_data, hit_block[31:0]} : {hit_block[63:32], bus.w_data};
            lru_en   = 1'b1;
            lru_val  = ~hit_way;
          end
        end else if (bus.mem_r_en) begin
          if (hit) begin
            ready   = 1'b1;
            r_data  = hit_word;
            lru_en  = 1'b1;
            lru_val = ~hit_way;
          end else begin
            state_d = FILL;
          end
        end else begin
          ready = 1'b1;
        end
      end
      FILL: begin
        sram_r_en    = 1'b1;
        sram_address = {bus.address[18:3], 3'b000};
        if (sram_done) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        sram_w_en    = 1'b1;
        sram_address = bus.address[18:0];
        sram_w_data  = bus.w_data;
        if (sram_done)
          state_d = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready        = ready;
  assign bus.r_data       = r_data;
  assign bus.sram_r_en    = sram_r_en;
  assign bus.sram_w_en    = sram_w_en;
  assign bus.sram_address = sram_address;
  assign bus.sram_w_data  = sram_w_data;

  // State register; first_q marks the first cycle after leaving IDLE (FILL/WRITE are only entered from IDLE).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      first_q <= (state_q == IDLE);
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic relookup_q;
  logic load_lookup;

  assign load_lookup = (state_q == IDLE) && !bus.mem_w_en && bus.mem_r_en;

  // Classify each load by its first lookup; the hit after a refill belongs to the miss already counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      relookup_q <= 1'b0;
    end else begin
      relookup_q <= (state_q == FILL) && sram_done;
      if (load_lookup && hit && !relookup_q && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (load_lookup && !hit && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed and randomized checks of cache_controller against
// a behavioural two-way LRU cache model and a backing-memory model.
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  cache_controller_if bus();

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  cache_controller dut (.clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count));
`else
  cache_controller dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Behavioural model state
  logic [63:0] backing_mem [int];
  bit          m_valid [64][2];
  logic [9:0]  m_tag   [64][2];
  logic [63:0] m_data  [64][2];
  bit          m_lru   [64];
  int          m_hits = 0;
  int          m_misses = 0;

  function automatic logic [63:0] backing(input logic [18:0] byte_addr);
    int key = int'(byte_addr[18:3]);
    if (!backing_mem.exists(key))
      backing_mem[key] = {$urandom, $urandom};
    return backing_mem[key];
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) begin
      m_valid[s][0] = 0;
      m_valid[s][1] = 0;
      m_lru[s] = 0;
    end
    m_hits = 0;
    m_misses = 0;
  endfunction

  function automatic int model_find(input int idx, input logic [9:0] tag);
    for (int w = 0; w < 2; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tag) return w;
    return -1;
  endfunction

  function automatic void model_load(input logic [31:0] addr, output bit hit, output logic [31:0] word);
    logic [31:0] a = addr - 32'd1024;
    int idx = int'(a[8:3]);
    int way = model_find(idx, a[18:9]);
    logic [63:0] blk;
    hit = (way >= 0);
    if (!hit) begin
      if (!m_valid[idx][0]) way = 0;
      else if (!m_valid[idx][1]) way = 1;
      else way = int'(m_lru[idx]);
      m_valid[idx][way] = 1;
      m_tag[idx][way] = a[18:9];
      m_data[idx][way] = backing(addr[18:0]);
      m_misses++;
    end else begin
      m_hits++;
    end
    m_lru[idx] = (way == 0);
    blk = m_data[idx][way];
    word = a[2] ? blk[63:32] : blk[31:0];
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] a = addr - 32'd1024;
    int idx = int'(a[8:3]);
    int way = model_find(idx, a[18:9]);
    logic [63:0] blk = backing(addr[18:0]);
    if (a[2]) blk[63:32] = data; else blk[31:0] = data;
    backing_mem[int'(addr[18:3])] = blk;
    if (way >= 0) begin
      blk = m_data[idx][way];
      if (a[2]) blk[63:32] = data; else blk[31:0] = data;
      m_data[idx][way] = blk;
      m_lru[idx] = (way == 0);
    end
  endfunction

  // One load transaction; the SRAM responder completes lat cycles after the first FILL cycle.
  task automatic load_txn(input logic [31:0] addr, input int lat, output int stall, output logic [31:0] rd,
                          output int fill_cycles, output logic [18:0] fill_addr, output bit timeout);
    @(posedge clk); #1;
    bus.mem_r_en = 1'b1;
    bus.mem_w_en = 1'b0;
    bus.address  = addr;
    bus.w_data   = $urandom;
    stall = 0; rd = '0; fill_cycles = 0; fill_addr = '0; timeout = 1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (bus.sram_r_en) begin
        if (fill_cycles == 0) fill_addr = bus.sram_address;
        bus.sram_r_data = backing(bus.sram_address);
        bus.sram_ready  = (fill_cycles == 0) || (fill_cycles == lat);
        fill_cycles++;
      end else begin
        bus.sram_ready = 1'b1;
      end
      #1;
      if (bus.ready) begin
        rd = bus.r_data;
        timeout = 0;
        break;
      end
      stall++;
      @(posedge clk); #1;
    end
  endtask

  // One store transaction; counts WRITE cycles and those carrying the right address/data.
  task automatic store_txn(input logic [31:0] addr, input logic [31:0] data, input int lat, output int stall,
                           output int wr_cycles, output int wr_ok, output bit timeout);
    @(posedge clk); #1;
    bus.mem_w_en = 1'b1;
    bus.mem_r_en = 1'($urandom_range(0, 1));
    bus.address  = addr;
    bus.w_data   = data;
    stall = 0; wr_cycles = 0; wr_ok = 0; timeout = 1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (bus.sram_w_en) begin
        if (bus.sram_address == addr[18:0] && bus.sram_w_data == data) wr_ok++;
        bus.sram_ready = (wr_cycles == 0) || (wr_cycles == lat);
        wr_cycles++;
      end else begin
        bus.sram_ready = 1'b1;
      end
      #1;
      if (bus.ready) begin
        timeout = 0;
        break;
      end
      stall++;
      @(posedge clk); #1;
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.sram_ready = 1'b1;
  endtask

  task automatic test_reset();
    bus.mem_r_en = 0; bus.mem_w_en = 0; bus.address = 32'h400; bus.w_data = 0;
    bus.sram_r_data = 0; bus.sram_ready = 1;
    rst = 1'b0;
    model_reset();
    #2;
    tests_run++; if (bus.ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready got %0b want 1", bus.ready); end
    tests_run++; if (bus.sram_r_en !== 1'b0 || bus.sram_w_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sram_en got %0b%0b want 00", bus.sram_r_en, bus.sram_w_en); end
    tests_run++; if (bus.sram_address !== 19'h0 || bus.r_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_outputs addr %h rdata %h want 0", bus.sram_address, bus.r_data); end
    bus.mem_r_en = 1'b1;
    #1;
    tests_run++; if (bus.ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready_req got %0b want 0", bus.ready); end
    bus.mem_r_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill();
    int stall, fc; logic [31:0] rd, exp; logic [18:0] fa; bit to, hit;
    backing_mem[int'(19'h400 >> 3)] = 64'h1111_1111_2222_2222;
    model_load(32'h400, hit, exp);
    load_txn(32'h400, 5, stall, rd, fc, fa, to);
    tests_run++; if (to) begin tests_failed++; $display("[TB] FAIL fill_timeout got timeout want ready"); end
    tests_run++; if (fa !== 19'h400) begin tests_failed++; $display("[TB] FAIL fill_address got %h want 00400", fa); end
    tests_run++; if (fc !== 6) begin tests_failed++; $display("[TB] FAIL fill_enable_cycles got %0d want 6", fc); end
    tests_run++; if (stall !== 7) begin tests_failed++; $display("[TB] FAIL fill_stall got %0d want 7", stall); end
    tests_run++; if (rd !== exp || rd !== 32'h2222_2222) begin tests_failed++; $display("[TB] FAIL fill_rdata got %h want %h", rd, exp); end
  endtask

  task automatic test_word_select();
    int stall, fc; logic [31:0] rd, exp; logic [18:0] fa; bit to, hit;
    model_load(32'h404, hit, exp);
    load_txn(32'h404, 3, stall, rd, fc, fa, to);
    tests_run++; if (stall !== 0 || fc !== 0 || to) begin tests_failed++; $display("[TB] FAIL hit_latency stall %0d fill %0d want 0 0", stall, fc); end
    tests_run++; if (rd !== 32'h1111_1111) begin tests_failed++; $display("[TB] FAIL hit_high_word got %h want 11111111", rd); end
  endtask

  task automatic test_lru();
    logic [31:0] seq [6] = '{32'h400, 32'h600, 32'h400, 32'hA00, 32'h400, 32'h600};
    int stall, fc, lat; logic [31:0] rd, exp; logic [18:0] fa; bit to, hit;
    for (int i = 0; i < 6; i++) begin
      lat = $urandom_range(1, 6);
      model_load(seq[i], hit, exp);
      load_txn(seq[i], lat, stall, rd, fc, fa, to);
      tests_run++;
      if (to || stall !== (hit ? 0 : lat + 2) || rd !== exp) begin
        tests_failed++;
        $display("[TB] FAIL lru_load%0d addr %h stall %0d rdata %h want stall %0d rdata %h", i, seq[i], stall, rd, hit ? 0 : lat + 2, exp);
      end
    end
  endtask

  task automatic test_write_hit();
    int stall, wc, ok, fc; logic [31:0] rd, exp; logic [18:0] fa; bit to, hit;
    model_store(32'h400, 32'hDEAD_BEEF);
    store_txn(32'h400, 32'hDEAD_BEEF, 4, stall, wc, ok, to);
    tests_run++; if (to || stall !== 6) begin tests_failed++; $display("[TB] FAIL store_stall got %0d want 6", stall); end
    tests_run++; if (wc !== 5 || ok !== 5) begin tests_failed++; $display("[TB] FAIL store_enable cycles %0d good %0d want 5 5", wc, ok); end
    model_load(32'h400, hit, exp);
    load_txn(32'h400, 2, stall, rd, fc, fa, to);
    tests_run++; if (stall !== 0 || rd !== 32'hDEAD_BEEF || exp !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL store_hit_reload stall %0d rdata %h want 0 deadbeef", stall, rd); end
  endtask

  task automatic test_write_miss();
    int stall, wc, ok, fc; logic [31:0] rd, exp; logic [18:0] fa; bit to, hit;
    model_store(32'h800, 32'h1234_5678);
    store_txn(32'h800, 32'h1234_5678, 3, stall, wc, ok, to);
    tests_run++; if (to || stall !== 5 || ok !== 4) begin tests_failed++; $display("[TB] FAIL store_miss stall %0d good %0d want 5 4", stall, ok); end
    model_load(32'h800, hit, exp);
    load_txn(32'h800, 2, stall, rd, fc, fa, to);
    tests_run++; if (stall !== 4 || fc !== 3 || rd !== exp) begin tests_failed++; $display("[TB] FAIL store_no_allocate stall %0d fill %0d rdata %h want 4 3 %h", stall, fc, rd, exp); end
  endtask

  task automatic test_reset_mid_fill();
    int stall, fc; logic [31:0] rd, exp; logic [18:0] fa; bit to, hit;
    @(posedge clk); #1;
    bus.mem_r_en = 1'b1; bus.mem_w_en = 1'b0; bus.address = 32'hC00; bus.sram_ready = 1'b1;
    @(posedge clk); #1;
    bus.sram_ready = 1'b0;
    tests_run++; if (bus.sram_r_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL midfill_enable got %0b want 1", bus.sram_r_en); end
    #2 rst = 1'b0;
    #1;
    tests_run++; if (bus.sram_r_en !== 1'b0 || bus.sram_address !== 19'h0) begin tests_failed++; $display("[TB] FAIL midfill_drop en %0b addr %h want 0 0", bus.sram_r_en, bus.sram_address); end
    tests_run++; if (bus.ready !== 1'b0 || bus.r_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL midfill_ready ready %0b rdata %h want 0 0", bus.ready, bus.r_data); end
    bus.mem_r_en = 1'b0;
    bus.sram_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    model_load(32'h400, hit, exp);
    load_txn(32'h400, 2, stall, rd, fc, fa, to);
    tests_run++; if (hit || stall !== 4 || fc !== 3 || rd !== exp) begin tests_failed++; $display("[TB] FAIL midfill_refetch stall %0d fill %0d rdata %h want 4 3 %h", stall, fc, rd, exp); end
  endtask

  task automatic test_random();
    int stall, fc, wc, ok, lat; logic [31:0] addr, rd, exp, data; logic [18:0] fa; bit to, hit;
    for (int i = 0; i < 80; i++) begin
      addr = 32'h400 + (32'($urandom_range(0, 3)) << 9) + (32'($urandom_range(0, 3)) << 3) + (32'($urandom_range(0, 1)) << 2);
      lat = $urandom_range(1, 6);
      if ($urandom_range(0, 9) < 7) begin
        model_load(addr, hit, exp);
        load_txn(addr, lat, stall, rd, fc, fa, to);
        tests_run++;
        if (to || stall !== (hit ? 0 : lat + 2) || rd !== exp || (!hit && fa !== {addr[18:3], 3'b000})) begin
          tests_failed++;
          $display("[TB] FAIL rand_load%0d addr %h stall %0d rdata %h fill %h want stall %0d rdata %h", i, addr, stall, rd, fa, hit ? 0 : lat + 2, exp);
        end
      end else begin
        data = $urandom;
        model_store(addr, data);
        store_txn(addr, data, lat, stall, wc, ok, to);
        tests_run++;
        if (to || stall !== lat + 2 || wc !== lat + 1 || ok !== lat + 1) begin
          tests_failed++;
          $display("[TB] FAIL rand_store%0d addr %h stall %0d cycles %0d good %0d want %0d %0d %0d", i, addr, stall, wc, ok, lat + 2, lat + 1, lat + 1);
        end
      end
    end
  endtask

  task automatic test_counters();
    go_idle();
    go_idle();
`ifdef CACHE_PERF_CNT_EN
    tests_run++; if (hit_count !== 32'(m_hits)) begin tests_failed++; $display("[TB] FAIL hit_count got %0d want %0d", hit_count, m_hits); end
    tests_run++; if (miss_count !== 32'(m_misses)) begin tests_failed++; $display("[TB] FAIL miss_count got %0d want %0d", miss_count, m_misses); end
`endif
    tests_run++; if (bus.ready !== 1'b1 || bus.sram_r_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_after_traffic ready %0b en %0b want 1 0", bus.ready, bus.sram_r_en); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_word_select();
    test_lru();
    test_write_hit();
    test_write_miss();
    test_reset_mid_fill();
    test_random();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative read cache between the MEM stage and the SRAM controller. Serves MEM-stage loads from on-chip tag/data arrays, refills 64-bit blocks from the SRAM controller on a read miss, and forwards every store to SRAM write-through. Drives `ready` low to freeze the pipeline while an SRAM transaction is outstanding.

## Interface
- `SETS`, 64: number of sets; index width is log2(SETS).
- `ADDR_OFFSET`, 1024: data-memory base; subtracted before field extraction.
- `clk` in 1: the single clock.
- `rst` in 1: reset. It is asynchronous and active-low; the block has one clock.
- `mem_r_en` in 1: load request from the MEM stage.
- `mem_w_en` in 1: store request; takes precedence if both enables are high.
- `address` in 32: byte address.
- `w_data` in 32: store data.
- `r_data` out 32: load data, combinational on hit.
- `ready` out 1: high means the request completes this cycle; low freezes the pipeline.
- `sram_r_en`, `sram_w_en` out 1: requests to the SRAM controller.
- `sram_address` out 19: byte address to the SRAM controller.
- `sram_w_data` out 32: store data to SRAM.
- `sram_r_data` in 64: refilled block.
- `sram_ready` in 1: SRAM controller completion.

## Operation
- Address split on `a = address - ADDR_OFFSET`: `a[2]` selects the word (0 = low half); `a[8:3]` is the index; `a[18:9]` is the 10-bit tag.
- Per set:
  - 2 ways, each holding valid, tag and 64-bit data.
  - One LRU bit naming the least-recently-used way.
- **IDLE**
  - Read hit: `ready` = 1 and `r_data` = selected word in the same cycle; LRU points at the other way.
  - Read miss: `ready` = 0; go to FILL.
  - Write: `ready` = 0; go to WRITE.
  - A write hit updates the cached word and LRU on the transition.
  - A write miss does not allocate.
  - No request: `ready` = 1.
- **FILL**
  - Outputs: `sram_r_en` = 1, `sram_address` = {`address[18:3]`, 3'b000}.
  - On completion, write `sram_r_data` into the LRU way, set valid and tag, then go to IDLE.
  - The re-lookup in IDLE hits and completes the load.
- **WRITE**
  - Outputs: `sram_w_en` = 1, `sram_address` = `address[18:0]`, `sram_w_data` = `w_data`.
  - On completion, go to DONE.
- **DONE**: `ready` = 1 for exactly one cycle; no lookup, no SRAM request; then IDLE.
- Request and completion rules:
  - The SRAM enable is held for the whole FILL/WRITE state.
  - `sram_ready` is ignored in the first cycle of FILL/WRITE, because the SRAM controller reports ready combinationally from its own idle state.
  - Completion is the first later cycle with `sram_ready` = 1.
  - The enable drops in the cycle after completion.
- Invalid ways are chosen before the LRU way on refill; if both are invalid, way 0 is used.
- Reset, asynchronous (also mid-FILL/WRITE):
  - State goes to IDLE.
  - All valid and LRU bits are cleared.
  - `sram_r_en`/`sram_w_en` = 0 immediately, `sram_address`/`sram_w_data`/`r_data` = 0.
  - `ready` = !(`mem_r_en` | `mem_w_en`).

## Timing
- Read hit: 0 stall cycles.
- Read miss: SRAM latency + 1 cycle (re-lookup).
- Store: SRAM latency + 1 cycle (DONE).
- Tag/data/valid/LRU updates take effect at the next rising `clk`.
- `r_data` and `ready` are combinational from the arrays and state. No other combinational path from `sram_*` inputs to `mem`-side outputs exists except `ready` through the state.

## Configuration
- `CACHE_PERF_CNT_EN` defined:
  - Adds ports `hit_count` out 32 and `miss_count` out 32.
  - Each counter increments once per completed load, classified by its first IDLE lookup.
  - Counters saturate at 0xFFFF_FFFF and are cleared by reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- `cache_pkg` holds:
  - the state enum (IDLE, FILL, WRITE, DONE);
  - `TAG_W` = 10, `IDX_W` = 6, `BLOCK_W` = 64;
  - `ADDR_OFFSET`.
- Sub-module `cache_set_array` owns valid/tag/data/LRU storage, hit detection and way selection. It provides a combinational lookup port and one synchronous write port. `cache_controller` holds the FSM and the SRAM handshake.

## Test plan
- Reset, then load 0x400 → FILL with `sram_r_en` = 1 and `sram_address` = 0x400.
  - SRAM returns 0x1111_1111_2222_2222 after 5 cycles.
  - After one re-lookup cycle, `ready` = 1 and `r_data` = 0x2222_2222.
- Load 0x404 next → `ready` = 1 in the same cycle, `r_data` = 0x1111_1111, `sram_r_en` stays 0.
- Load 0x400, 0x600, 0x400, 0xA00 (all index 0) → 0x600 is evicted; load 0x600 then misses, and load 0x400 hits.
- Store 0xDEADBEEF to 0x400 after it is cached:
  - `sram_w_en` is held with `sram_w_data` = 0xDEADBEEF.
  - `ready` = 1 only in DONE.
  - A following load 0x400 hits and returns 0xDEADBEEF.
- Store to 0x800 (not cached) → SRAM write only; a following load 0x800 misses.
- Assert `rst` low mid-FILL → `sram_r_en` drops immediately; after release, load 0x400 misses again.
